// File: rtl/bcd_disp_pkg.sv
// Purpose : shared types and constants for the 3-digit BCD scanned display.
// Latency : n/a (package only).
// Backpr. : n/a (package only).
//
// Contents: scan-state enumeration, active-low {g,f,e,d,c,b,a} segment
// patterns for digits 0-9, DASH and BLANK, and the digit count.
package bcd_disp_pkg;

    localparam int NUM_DIGITS = 3;

    // One display slot per digit, each followed by an all-off gap so the
    // segment lines settle before the next anode turns on.
    typedef enum logic [2:0] {
        D0   = 3'd0,
        GAP0 = 3'd1,
        D1   = 3'd2,
        GAP1 = 3'd3,
        D2   = 3'd4,
        GAP2 = 3'd5
    } scan_state_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_decode.sv
// Purpose : nibble to active-low 7-segment pattern; 10-15 show a dash.
// Latency : combinational, zero cycles.
// Backpr. : none.
//
// Ports: nib [3:0] digit value, blank forces all segments off,
//        seg [6:0] {g,f,e,d,c,b,a} active-low.
module seg7_decode
    import bcd_disp_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            case (nib)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/bcd_disp_mux.sv
// Purpose : time-multiplexed driver for a 3-digit BCD seven-segment display.
// Latency : outputs combinational from scan state; a load becomes visible at the next D0 (<= 6*REFRESH_DIV+1 cycles).
// Backpr. : none; load is a strobe into a pending register, newest value wins.
//
// Ports: clk, rst_n (async active-low); bcd_in[11:8|7:4|3:0] = hundreds|tens|units,
//        load strobe; an[3:0] active-low anodes (an[3] unused, held 1);
//        seg[6:0] {g,f,e,d,c,b,a} active-low; dp held 1; err = invalid nibble shown.
// Build option: define BCD_DISP_LZB_EN to blank leading zeros (units never blanked).
module bcd_disp_mux
    import bcd_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] bcd_in,
    input  logic        load,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        err
);

    localparam logic [19:0] CNT_MAX = 20'(REFRESH_DIV - 1);

    logic [19:0]               cnt;
    logic                      tick;
    scan_state_t               state;
    logic [NUM_DIGITS*4-1:0]   pend;
    logic [NUM_DIGITS*4-1:0]   disp;

    logic [3:0]                hund;
    logic [3:0]                tens;
    logic [3:0]                units;
    logic                      blank_hund;
    logic                      blank_tens;

    logic [3:0]                mux_nib;
    logic                      mux_blank;

    // Scan prescaler
    assign tick = (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 20'd1;
        end
    end

    // Scan FSM plus pending/display registers. The display register only
    // changes on the GAP2->D0 step so a frame never mixes old and new digits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= GAP2;
            pend  <= '0;
            disp  <= '0;
        end else begin
            if (load) begin
                pend <= bcd_in;
            end
            if (tick) begin
                case (state)
                    D0:   state <= GAP0;
                    GAP0: state <= D1;
                    D1:   state <= GAP1;
                    GAP1: state <= D2;
                    D2:   state <= GAP2;
                    GAP2: begin
                        state <= D0;
                        disp  <= pend;
                    end
                    default: state <= GAP2;
                endcase
            end
        end
    end

    assign hund  = disp[11:8];
    assign tens  = disp[7:4];
    assign units = disp[3:0];

    // Only zero nibbles are ever blanked, so an invalid digit keeps its dash.
`ifdef BCD_DISP_LZB_EN
    assign blank_hund = (hund == 4'd0);
    assign blank_tens = (hund == 4'd0) && (tens == 4'd0);
`else
    assign blank_hund = 1'b0;
    assign blank_tens = 1'b0;
`endif

    // Digit select: gaps drive everything off through the decoder's blank.
    always_comb begin
        an        = 4'b1111;
        mux_nib   = units;
        mux_blank = 1'b1;
        case (state)
            D0: begin
                an        = 4'b1110;
                mux_nib   = units;
                mux_blank = 1'b0;
            end
            D1: begin
                an        = 4'b1101;
                mux_nib   = tens;
                mux_blank = blank_tens;
            end
            D2: begin
                an        = 4'b1011;
                mux_nib   = hund;
                mux_blank = blank_hund;
            end
            default: begin
                an        = 4'b1111;
                mux_nib   = units;
                mux_blank = 1'b1;
            end
        endcase
    end

    seg7_decode u_seg7 (
        .nib   (mux_nib),
        .blank (mux_blank),
        .seg   (seg)
    );

    assign dp  = 1'b1;
    assign err = (hund > 4'd9) || (tens > 4'd9) || (units > 4'd9);

endmodule

// File: tb/tb_bcd_disp_mux.sv
// Purpose : self-checking bench for bcd_disp_mux with REFRESH_DIV=4 (24-cycle frame).
// Latency : expected digit slots queued per frame, popped when each anode turns on.
// Backpr. : n/a.
module tb_bcd_disp_mux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] bcd_in;
    logic        load;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        err;

    bcd_disp_mux #(.REFRESH_DIV(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bcd_in (bcd_in),
        .load   (load),
        .an     (an),
        .seg    (seg),
        .dp     (dp),
        .err    (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         k;
        logic [3:0] an;
        logic [6:0] seg;
        logic       err;
    } slot_t;

    slot_t      sb[$];
    slot_t      got_slot;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         k;
    logic [3:0] prev_an = 4'hF;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] exp_seg(input logic [3:0] n, input bit blank);
        if (blank) return 7'b1111111;
        case (n)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // Queue the three digit slots of a frame whose D0 begins at cycle start.
    function automatic void push_frame(input logic [11:0] v, input int start);
        slot_t s;
        bit    bh;
        bit    bt;
        logic  e;
`ifdef BCD_DISP_LZB_EN
        bh = (v[11:8] == 4'd0);
        bt = (v[11:8] == 4'd0) && (v[7:4] == 4'd0);
`else
        bh = 1'b0;
        bt = 1'b0;
`endif
        e = (v[3:0] > 4'd9) || (v[7:4] > 4'd9) || (v[11:8] > 4'd9);
        s.err = e;
        s.k = start;      s.an = 4'b1110; s.seg = exp_seg(v[3:0], 1'b0); sb.push_back(s);
        s.k = start + 8;  s.an = 4'b1101; s.seg = exp_seg(v[7:4], bt);   sb.push_back(s);
        s.k = start + 16; s.an = 4'b1011; s.seg = exp_seg(v[11:8], bh);  sb.push_back(s);
    endfunction

    // Cycles elapsed since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end

    // Monitor: an anode turning on is a produced digit slot.
    always @(negedge clk) begin
        if (rst_n) begin
            if (an != 4'hF && prev_an == 4'hF) begin
                check("sb_nonempty", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    got_slot = sb.pop_front();
                    check("slot_cycle", k, got_slot.k);
                    check("slot_an", an, got_slot.an);
                    check("slot_seg", seg, got_slot.seg);
                    check("slot_err", err, got_slot.err);
                    check("slot_dp", dp, 1);
                end
            end else if (an == 4'hF && prev_an != 4'hF) begin
                check("gap_seg", seg, 7'h7F);
            end
        end
        prev_an = an;
    end

    task automatic release_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("rel_gap_an", an, 4'hF);
            @(posedge clk); #1;
        end
    endtask

    // Run one 24-cycle frame that should show 'shown'; optional loads at
    // offsets off_a/off_b, optional reset assertion at rst_off (ends frame).
    task automatic run_frame(input logic [11:0] shown,
                             input int off_a, input logic [11:0] val_a,
                             input int off_b, input logic [11:0] val_b,
                             input int rst_off);
        push_frame(shown, k);
        for (int c = 0; c < 24; c++) begin
            if (c == rst_off) begin
                load  = 1'b0;
                rst_n = 1'b0;
                #1;
                check("rst_mid_an", an, 4'hF);
                check("rst_mid_seg", seg, 7'h7F);
                check("rst_mid_dp", dp, 1);
                check("rst_mid_err", err, 0);
                return;
            end
            load   = (c == off_a) || (c == off_b);
            bcd_in = (c == off_b) ? val_b : val_a;
            @(posedge clk); #1;
        end
        load = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n  = 1'b0;
        load   = 1'b0;
        bcd_in = 12'h000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 7'h7F);
        check("rst_dp", dp, 1);
        check("rst_err", err, 0);

        release_reset();
        run_frame(12'h000, 10, 12'h259, -1, 12'h000, -1);
        run_frame(12'h259,  3, 12'h111,  5, 12'h222, -1);
        run_frame(12'h222, 12, 12'h0A3, -1, 12'h000, -1);
        run_frame(12'h0A3, 20, 12'h003, -1, 12'h000, -1);
        run_frame(12'h003,  6, 12'h007, -1, 12'h000, -1);
        run_frame(12'h007,  2, 12'h456, -1, 12'h000,  9);

        // Reset landed in D1, so only the D2 slot of that frame is outstanding.
        check("sb_pre_rst", sb.size(), 1);
        sb.delete();
        repeat (3) @(posedge clk);
        #1;

        // The pending 456 must have been discarded by reset.
        release_reset();
        run_frame(12'h000, -1, 12'h000, -1, 12'h000, -1);
        run_frame(12'h000, -1, 12'h000, -1, 12'h000, -1);
        check("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
